// File: rtl/ib_seq_pkg.sv
// rtl/ib_seq_pkg.sv - shared constants and types for the internal-bus sequencer
// Contents: opcode constants, IB driver codes, FSM state codes, decoded control word.
package ib_seq_pkg;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDA  = 4'h1;
   localparam logic [3:0] OP_LDB  = 4'h2;
   localparam logic [3:0] OP_ADD  = 4'h3;
   localparam logic [3:0] OP_SUB  = 4'h4;
   localparam logic [3:0] OP_OUTA = 4'h5;
   localparam logic [3:0] OP_OUTI = 4'h6;
   localparam logic [3:0] OP_JMP  = 4'h7;
   localparam logic [3:0] OP_JZ   = 4'h8;
   localparam logic [3:0] OP_HLT  = 4'hF;

   localparam logic [1:0] BUS_NONE = 2'd0;
   localparam logic [1:0] BUS_IMM  = 2'd1;
   localparam logic [1:0] BUS_ALU  = 2'd2;
   localparam logic [1:0] BUS_A    = 2'd3;

   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_FETCH  = 3'd1;
   localparam state_t ST_DECODE = 3'd2;
   localparam state_t ST_EXEC   = 3'd3;
   localparam state_t ST_HALT   = 3'd4;

   typedef struct packed {
      logic [1:0] bussel;
      logic       aluop;
      logic       lda;
      logic       ldb;
      logic       ldout;
      logic       jmp;
      logic       jz;
      logic       hlt;
      logic       illegal;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/ib_seq_decode.sv
// rtl/ib_seq_decode.sv - combinational opcode to control-word decoder
// Ports: opcode (in, 4) instruction opcode; ctrl (out, ctrl_t) decoded control word.
// Macro IB_SEQ_ILLEGAL_TRAP_EN: undefined opcodes also request HALT instead of acting as NOP.
module ib_seq_decode
   import ib_seq_pkg::*;
(
   input  logic [3:0] opcode,
   output ctrl_t      ctrl
);

   always_comb begin
      ctrl = CTRL_NOP;
      case (opcode)
         OP_NOP: ctrl = CTRL_NOP;
         OP_LDA: begin
            ctrl.bussel = BUS_IMM;
            ctrl.lda    = 1'b1;
         end
         OP_LDB: begin
            ctrl.bussel = BUS_IMM;
            ctrl.ldb    = 1'b1;
         end
         OP_ADD: begin
            ctrl.bussel = BUS_ALU;
            ctrl.lda    = 1'b1;
         end
         OP_SUB: begin
            ctrl.bussel = BUS_ALU;
            ctrl.aluop  = 1'b1;
            ctrl.lda    = 1'b1;
         end
         OP_OUTA: begin
            ctrl.bussel = BUS_A;
            ctrl.ldout  = 1'b1;
         end
         OP_OUTI: begin
            ctrl.bussel = BUS_IMM;
            ctrl.ldout  = 1'b1;
         end
         OP_JMP: ctrl.jmp = 1'b1;
         OP_JZ:  ctrl.jz  = 1'b1;
         OP_HLT: ctrl.hlt = 1'b1;
         default: begin
            // Undefined opcodes never drive the bus or strobe anything.
            ctrl.illegal = 1'b1;
`ifdef IB_SEQ_ILLEGAL_TRAP_EN
            ctrl.hlt     = 1'b1;
`else
            ctrl.hlt     = 1'b0;
`endif
         end
      endcase
   end

endmodule

// File: rtl/ib_bus_sequencer.sv
// rtl/ib_bus_sequencer.sv - 3-cycle micro-sequencer selecting the IB[3:0] driver
// Ports: MainClock/MainReset (sync, active-low); Run, Step, Instr[7:0], AluZero in;
//        PC[PC_W-1:0], BusSel[1:0], ImmOut[3:0], AluOp, LoadA, LoadB, LoadOut,
//        Busy, Halted, IllegalOp out.
// Macro IB_SEQ_ILLEGAL_TRAP_EN (see ib_seq_decode): undefined opcodes halt.
module ib_bus_sequencer
   import ib_seq_pkg::*;
#(
   parameter int              PC_W     = 4,
   parameter logic [PC_W-1:0] RESET_PC = '0
)(
   input  logic            MainClock,
   input  logic            MainReset,
   input  logic            Run,
   input  logic            Step,
   input  logic [7:0]      Instr,
   input  logic            AluZero,
   output logic [PC_W-1:0] PC,
   output logic [1:0]      BusSel,
   output logic [3:0]      ImmOut,
   output logic            AluOp,
   output logic            LoadA,
   output logic            LoadB,
   output logic            LoadOut,
   output logic            Busy,
   output logic            Halted,
   output logic            IllegalOp
);

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [7:0]      ir_q, ir_d;
   ctrl_t           ctrl_q, ctrl_d;
   logic            illegal_q, illegal_d;
   // Set once Run has been seen low in HALT; the next Run=1 then restarts.
   logic            armed_q, armed_d;

   ctrl_t           dec_ctrl;
   logic [PC_W-1:0] imm_pc;
   logic            in_exec;

   ib_seq_decode u_decode (
      .opcode (ir_q[7:4]),
      .ctrl   (dec_ctrl)
   );

   // Immediate zero-extended or truncated to the PC width.
   always_comb begin
      imm_pc = '0;
      for (int i = 0; i < PC_W && i < 4; i++) imm_pc[i] = ir_q[i];
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      ctrl_d    = ctrl_q;
      illegal_d = illegal_q;
      armed_d   = armed_q;
      case (state_q)
         ST_IDLE: begin
            if (Run || Step) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            ir_d    = Instr;
            state_d = ST_DECODE;
         end
         ST_DECODE: begin
            ctrl_d  = dec_ctrl;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            if (ctrl_q.illegal) illegal_d = 1'b1;
            if (ctrl_q.hlt) begin
               // PC stays on the halting instruction.
               state_d = ST_HALT;
               armed_d = 1'b0;
            end else begin
               if (ctrl_q.jmp || (ctrl_q.jz && AluZero)) pc_d = imm_pc;
               else                                      pc_d = pc_q + PC_W'(1);
               state_d = Run ? ST_FETCH : ST_IDLE;
            end
         end
         ST_HALT: begin
            if (!Run) begin
               armed_d = 1'b1;
            end else if (armed_q) begin
               state_d = ST_IDLE;
               pc_d    = RESET_PC;
               armed_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge MainClock) begin
      if (!MainReset) begin
         state_q   <= ST_IDLE;
         pc_q      <= RESET_PC;
         ir_q      <= '0;
         ctrl_q    <= CTRL_NOP;
         illegal_q <= 1'b0;
         armed_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         ctrl_q    <= ctrl_d;
         illegal_q <= illegal_d;
         armed_q   <= armed_d;
      end
   end

   // All outputs come straight from flops; the registered control word is
   // only exposed during EXEC so strobes last exactly one cycle.
   assign in_exec   = (state_q == ST_EXEC);
   assign PC        = pc_q;
   assign ImmOut    = ir_q[3:0];
   assign BusSel    = in_exec ? ctrl_q.bussel : BUS_NONE;
   assign AluOp     = in_exec & ctrl_q.aluop;
   assign LoadA     = in_exec & ctrl_q.lda;
   assign LoadB     = in_exec & ctrl_q.ldb;
   assign LoadOut   = in_exec & ctrl_q.ldout;
   assign Busy      = (state_q == ST_FETCH) || (state_q == ST_DECODE) || in_exec;
   assign Halted    = (state_q == ST_HALT);
   assign IllegalOp = illegal_q;

endmodule

// File: tb/tb_ib_bus_sequencer.sv
// tb/tb_ib_bus_sequencer.sv - directed self-checking bench for ib_bus_sequencer
module tb_ib_bus_sequencer;

   logic       MainClock = 1'b0;
   logic       MainReset = 1'b0;
   logic       Run = 1'b0;
   logic       Step = 1'b0;
   logic [7:0] Instr;
   logic       AluZero = 1'b0;
   logic [3:0] PC;
   logic [1:0] BusSel;
   logic [3:0] ImmOut;
   logic       AluOp, LoadA, LoadB, LoadOut, Busy, Halted, IllegalOp;

   logic [7:0] mem [0:15];
   assign Instr = mem[PC];

   always #5 MainClock = ~MainClock;

   ib_bus_sequencer #(.PC_W(4), .RESET_PC(4'd0)) dut (
      .MainClock (MainClock),
      .MainReset (MainReset),
      .Run       (Run),
      .Step      (Step),
      .Instr     (Instr),
      .AluZero   (AluZero),
      .PC        (PC),
      .BusSel    (BusSel),
      .ImmOut    (ImmOut),
      .AluOp     (AluOp),
      .LoadA     (LoadA),
      .LoadB     (LoadB),
      .LoadOut   (LoadOut),
      .Busy      (Busy),
      .Halted    (Halted),
      .IllegalOp (IllegalOp)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [3:0] pc0;
      logic [7:0] instr;
      logic       az;
      logic [1:0] bs;
      logic       aop;
      logic       la;
      logic       lb;
      logic       lo;
      logic [3:0] pc1;
      logic       ill;
      logic       hlt;
   } vec_t;

   vec_t vt [15];

   task automatic do_reset();
      MainReset = 1'b0;
      Run = 1'b0;
      Step = 1'b0;
      AluZero = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      @(negedge MainClock);
      @(negedge MainClock);
      MainReset = 1'b1;
   endtask

   // Called at a negedge while IDLE; runs one single-stepped instruction.
   task automatic step_one(output logic [1:0] bs, output logic [3:0] imm,
                           output logic aop, output logic la, output logic lb,
                           output logic lo, output int nstb);
      nstb = 0;
      Step = 1'b1;
      @(negedge MainClock);             // FETCH
      Step = 1'b0;
      nstb += int'(LoadA) + int'(LoadB) + int'(LoadOut);
      @(negedge MainClock);             // DECODE
      nstb += int'(LoadA) + int'(LoadB) + int'(LoadOut);
      @(negedge MainClock);             // EXEC
      bs = BusSel; imm = ImmOut; aop = AluOp;
      la = LoadA; lb = LoadB; lo = LoadOut;
      nstb += int'(LoadA) + int'(LoadB) + int'(LoadOut);
      @(negedge MainClock);             // IDLE or HALT
      nstb += int'(LoadA) + int'(LoadB) + int'(LoadOut);
   endtask

   logic [1:0] s_bs;
   logic [3:0] s_imm;
   logic       s_aop, s_la, s_lb, s_lo;
   int         s_n;

   // Program-run event log
   logic [1:0] ev_bs [8];
   logic [3:0] ev_imm [8];
   logic       ev_aop [8];
   logic [2:0] ev_stb [8];   // {LoadOut, LoadB, LoadA}
   int         n_ev;
   int         lo_seen;
   int         la_count;
   logic       ill_exp_halt;

   initial begin
`ifdef IB_SEQ_ILLEGAL_TRAP_EN
      ill_exp_halt = 1'b1;
`else
      ill_exp_halt = 1'b0;
`endif
      //          pc0    instr  az    bs     aop   la    lb    lo    pc1    ill   hlt
      vt[0]  = '{4'd0,  8'h13, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1,  1'b0, 1'b0};
      vt[1]  = '{4'd0,  8'h22, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1,  1'b0, 1'b0};
      vt[2]  = '{4'd0,  8'h30, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1,  1'b0, 1'b0};
      vt[3]  = '{4'd0,  8'h45, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1,  1'b0, 1'b0};
      vt[4]  = '{4'd0,  8'h50, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1,  1'b0, 1'b0};
      vt[5]  = '{4'd0,  8'h69, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1,  1'b0, 1'b0};
      vt[6]  = '{4'd0,  8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1,  1'b0, 1'b0};
      vt[7]  = '{4'd3,  8'h8A, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd10, 1'b0, 1'b0};
      vt[8]  = '{4'd3,  8'h8A, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4,  1'b0, 1'b0};
      vt[9]  = '{4'd15, 8'h7F, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd15, 1'b0, 1'b0};
      vt[10] = '{4'd15, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0};
      vt[11] = '{4'd5,  8'h7C, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd12, 1'b0, 1'b0};
      vt[12] = '{4'd6,  8'hF0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd6,  1'b0, 1'b1};
      vt[13] = '{4'd2,  8'hA3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                 ill_exp_halt ? 4'd2 : 4'd3, 1'b1, ill_exp_halt};
      vt[14] = '{4'd0,  8'h8B, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd11, 1'b0, 1'b0};

      // Reset state
      do_reset();
      chk("rst_pc", 32'(PC), 32'd0);
      chk("rst_bussel", 32'(BusSel), 32'd0);
      chk("rst_strobes", {29'd0, LoadOut, LoadB, LoadA}, 32'd0);
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_halted", 32'(Halted), 32'd0);
      chk("rst_illegal", 32'(IllegalOp), 32'd0);
      chk("rst_immout", 32'(ImmOut), 32'd0);

      // Table-driven single-instruction vectors
      for (int v = 0; v < 15; v++) begin
         do_reset();
         if (vt[v].pc0 != 4'd0) begin
            mem[0] = {4'h7, vt[v].pc0};
            step_one(s_bs, s_imm, s_aop, s_la, s_lb, s_lo, s_n);
         end
         mem[vt[v].pc0] = vt[v].instr;
         AluZero = vt[v].az;
         step_one(s_bs, s_imm, s_aop, s_la, s_lb, s_lo, s_n);
         chk($sformatf("v%0d_bussel", v), 32'(s_bs), 32'(vt[v].bs));
         if (vt[v].bs == 2'd1) chk($sformatf("v%0d_immout", v), 32'(s_imm), 32'(vt[v].instr[3:0]));
         if (vt[v].bs == 2'd2) chk($sformatf("v%0d_aluop", v), 32'(s_aop), 32'(vt[v].aop));
         chk($sformatf("v%0d_strobes", v), {29'd0, s_lo, s_lb, s_la},
             {29'd0, vt[v].lo, vt[v].lb, vt[v].la});
         chk($sformatf("v%0d_nstrobe", v), 32'(s_n),
             32'(int'(vt[v].lo) + int'(vt[v].lb) + int'(vt[v].la)));
         chk($sformatf("v%0d_pc", v), 32'(PC), 32'(vt[v].pc1));
         chk($sformatf("v%0d_illegal", v), 32'(IllegalOp), 32'(vt[v].ill));
         chk($sformatf("v%0d_halted", v), 32'(Halted), 32'(vt[v].hlt));
         chk($sformatf("v%0d_busy", v), 32'(Busy), 32'd0);
      end

      // Free-running program
      do_reset();
      mem[0] = 8'h13; mem[1] = 8'h22; mem[2] = 8'h30; mem[3] = 8'h50; mem[4] = 8'hF0;
      Run = 1'b1;
      n_ev = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge MainClock);
         if ((LoadA || LoadB || LoadOut) && n_ev < 8) begin
            ev_bs[n_ev] = BusSel; ev_imm[n_ev] = ImmOut; ev_aop[n_ev] = AluOp;
            ev_stb[n_ev] = {LoadOut, LoadB, LoadA};
            n_ev++;
         end
         if (Halted) break;
      end
      chk("prog_halted", 32'(Halted), 32'd1);
      chk("prog_events", 32'(n_ev), 32'd4);
      if (n_ev == 4) begin
         chk("prog_e0", {26'd0, ev_stb[0], ev_bs[0], ev_imm[0][0]}, {26'd0, 3'b001, 2'd1, 1'b1});
         chk("prog_e0_imm", 32'(ev_imm[0]), 32'd3);
         chk("prog_e1", {27'd0, ev_stb[1], ev_bs[1]}, {27'd0, 3'b010, 2'd1});
         chk("prog_e1_imm", 32'(ev_imm[1]), 32'd2);
         chk("prog_e2", {26'd0, ev_stb[2], ev_bs[2], ev_aop[2]}, {26'd0, 3'b001, 2'd2, 1'b0});
         chk("prog_e3", {27'd0, ev_stb[3], ev_bs[3]}, {27'd0, 3'b100, 2'd3});
      end
      // HALT holds PC and ignores Step
      Step = 1'b1;
      @(negedge MainClock);
      Step = 1'b0;
      repeat (3) @(negedge MainClock);
      chk("halt_pc_frozen", 32'(PC), 32'd4);
      chk("halt_hold", {30'd0, Halted, Busy}, {30'd0, 1'b1, 1'b0});
      // Run 0 -> 1 releases HALT into IDLE at RESET_PC
      Run = 1'b0;
      @(negedge MainClock);
      Run = 1'b1;
      @(negedge MainClock);
      Run = 1'b0;
      chk("halt_exit", {27'd0, PC, Halted}, {27'd0, 4'd0, 1'b0});
      chk("halt_exit_busy", 32'(Busy), 32'd0);

      // Reset asserted during DECODE with Run=1
      do_reset();
      mem[0] = 8'h69;
      Run = 1'b1;
      lo_seen = 0;
      @(negedge MainClock);              // FETCH
      @(negedge MainClock);              // DECODE
      chk("mid_in_decode", 32'(Busy), 32'd1);
      MainReset = 1'b0;
      @(negedge MainClock);
      lo_seen += int'(LoadOut);
      chk("mid_rst_state", {26'd0, PC, Busy, BusSel[0]}, 32'd0);
      chk("mid_rst_strobes", {29'd0, LoadOut, LoadB, LoadA}, 32'd0);
      Run = 1'b0;
      MainReset = 1'b1;
      repeat (4) begin
         @(negedge MainClock);
         lo_seen += int'(LoadOut);
      end
      chk("mid_rst_no_loadout", 32'(lo_seen), 32'd0);

      // Step while Busy is ignored; Step in IDLE runs exactly one instruction
      do_reset();
      mem[0] = 8'h13; mem[1] = 8'h13; mem[2] = 8'h13;
      la_count = 0;
      Step = 1'b1;
      @(negedge MainClock);              // FETCH
      Step = 1'b0;
      la_count += int'(LoadA);
      Step = 1'b1;
      @(negedge MainClock);              // DECODE
      Step = 1'b0;
      la_count += int'(LoadA);
      repeat (6) begin
         @(negedge MainClock);
         la_count += int'(LoadA);
      end
      chk("busy_step_loada", 32'(la_count), 32'd1);
      chk("busy_step_pc", 32'(PC), 32'd1);
      chk("busy_step_idle", 32'(Busy), 32'd0);

      // Run dropping mid-instruction: finishes the current one, then IDLE
      do_reset();
      Run = 1'b1;
      @(negedge MainClock);              // FETCH
      Run = 1'b0;
      repeat (5) @(negedge MainClock);
      chk("run_drop_pc", 32'(PC), 32'd1);
      chk("run_drop_idle", 32'(Busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=%0d expected=%0d", 1, 0);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ib_bus_sequencer.md
Name: ib_bus_sequencer

Overview:
- Micro-sequencer for the 4-bit internal-bus datapath.
- Fetches 8-bit instructions from program memory and selects the single driver of IB[3:0] each cycle.
- Issues one-cycle load strobes to register A, register B and the output register.
- The output register's LoadOut input is driven directly by this block; no other logic asserts LoadOut.

Parameters:
PC_W, 4, program-counter width; program memory holds 2**PC_W words
RESET_PC, 0, PC value after reset and after a halt is cleared by Run=0

Ports:
MainClock  input  1  system clock; all state updates on rising edge
MainReset  input  1  synchronous, active-low reset
Run  input  1  level; 1 = free-run, 0 = single-step mode
Step  input  1  one-cycle pulse; executes one instruction when Run=0
Instr  input  8  program word at address PC; [7:4] opcode, [3:0] immediate
AluZero  input  1  ALU result-is-zero flag, sampled in EXEC
PC  output  PC_W  program memory address
BusSel  output  2  IB driver: 0 none, 1 immediate, 2 ALU, 3 register A
ImmOut  output  4  immediate value driven onto IB when BusSel=1
AluOp  output  1  0 add, 1 subtract
LoadA  output  1  register A load strobe
LoadB  output  1  register B load strobe
LoadOut  output  1  output register load strobe
Busy  output  1  high while an instruction is in flight
Halted  output  1  high in HALT state
IllegalOp  output  1  sticky; set on an undefined opcode

Behaviour:
- Reset (MainReset=0 at a clock edge): state IDLE, PC=RESET_PC, IR=0, BusSel=0, ImmOut=0, AluOp=0, all strobes 0, Busy=0, Halted=0, IllegalOp=0. Reset overrides everything, including mid-instruction; no strobe is emitted in the reset cycle.
- States and transitions:
  - IDLE -> FETCH when Run=1, or when Run=0 and Step=1.
  - FETCH: IR<=Instr.
  - DECODE: control word registered.
  - EXEC: strobes and BusSel valid; PC update at the end of EXEC.
  - EXEC -> FETCH if Run=1, else -> IDLE.
- Every instruction takes exactly 3 cycles. Busy=1 in FETCH, DECODE and EXEC.
- Outside EXEC: BusSel=0 and all strobes are 0.
- Strobes are high for exactly one full cycle. At most one strobe per instruction.
- Opcodes:
  - 0 NOP
  - 1 LDA: BusSel=1, LoadA
  - 2 LDB: BusSel=1, LoadB
  - 3 ADD: BusSel=2, AluOp=0, LoadA
  - 4 SUB: BusSel=2, AluOp=1, LoadA
  - 5 OUTA: BusSel=3, LoadOut
  - 6 OUTI: BusSel=1, LoadOut
  - 7 JMP: PC<=imm
  - 8 JZ: PC<=imm if AluZero=1, else PC+1
  - F HLT: -> HALT
  - 9-E: undefined
- PC update:
  - PC<=PC+1 except on a taken jump.
  - PC wraps modulo 2**PC_W (from all-ones to 0).
  - Immediate is zero-extended or truncated to PC_W.
- HALT: Halted=1, Busy=0, PC frozen, Step ignored. Leave HALT only via reset, or via Run=0 then Run=1, which goes to IDLE with PC=RESET_PC.
- Step arriving while Busy=1 is ignored and not queued.
- Run dropping mid-instruction: the current instruction completes, then IDLE.

Optional Feature:
- Macro: IB_SEQ_ILLEGAL_TRAP_EN.
- Defined: an undefined opcode sets IllegalOp and enters HALT at the end of EXEC, with no strobe.
- Undefined: an undefined opcode sets IllegalOp and executes as NOP.
- IllegalOp is cleared only by reset in both cases.

Decomposition:
- Shared package ib_seq_pkg:
  - opcode constants OP_NOP..OP_HLT
  - BusSel codes BUS_NONE, BUS_IMM, BUS_ALU, BUS_A
  - state enum IDLE/FETCH/DECODE/EXEC/HALT
  - control-word struct {bussel, aluop, lda, ldb, ldout, jmp, jz, hlt, illegal}
- Sub-module ib_seq_decode: purely combinational, opcode -> control word.
- The FSM and PC logic stay in ib_bus_sequencer.

Test Plan:
- Reset mid-DECODE with Run=1 -> next cycle state IDLE, PC=0, all strobes 0, no LoadOut pulse.
- Program {0x13, 0x22, 0x30, 0x50, 0xF0}, Run=1 ->
  - LoadA with ImmOut=3; LoadB with ImmOut=2; LoadA with BusSel=2 and AluOp=0; LoadOut with BusSel=3.
  - Halted=1 after 15 cycles, PC frozen at 4.
- JZ 0x8A with AluZero=1 -> PC=10; with AluZero=0 -> PC advances by 1. JMP 0x7F at PC=15 -> PC=15; NOP at PC=15 -> PC wraps to 0.
- Run=0, Step pulsed while Busy=1 -> ignored. Step while IDLE -> exactly one instruction executes, then IDLE.
- Opcode 0xA:
  - with IB_SEQ_ILLEGAL_TRAP_EN -> IllegalOp=1, Halted=1, no strobe.
  - without it -> IllegalOp=1, execution continues at PC+1.
